// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding
// and the default operand width.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full-adder cell shared across arithmetic blocks.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = X - Y (X + ~Y + 1), LSB first, one full-adder per clock.
// Optional two's-complement overflow output when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] D,
    output logic             borrow,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] acc_next;

    FullAdder u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (carry_out)
    );

    // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign acc_next = {sum_bit, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            D      <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        opa   <= X;
                        opb   <= ~Y;
                        carry <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= carry_out;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        D      <= acc_next;
                        borrow <= ~carry_out;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= carry ^ carry_out;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases plus randomized traffic against
// a cycle-level behavioural model of the subtractor.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [W-1:0] D;
    logic         borrow;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .X      (X),
        .Y      (Y),
        .D      (D),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation occupies W edges after acceptance.
    int           rem = 0;
    logic [W-1:0] mx, my;
    int           m_d = 0;
    int           m_b = 0;
    int           m_o = 0;
    int           m_done = 0;

    always @(posedge clk) begin
        int diff;
        if (!rst_n) begin
            rem = 0; m_d = 0; m_b = 0; m_o = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_d    = (int'(mx) - int'(my)) & ((1 << W) - 1);
                    m_b    = (mx < my) ? 1 : 0;
                    diff   = int'($signed(mx)) - int'($signed(my));
                    m_o    = (diff > (1 << (W - 1)) - 1 || diff < -(1 << (W - 1))) ? 1 : 0;
                    m_done = 1;
                end
            end else if (start) begin
                mx  = X;
                my  = Y;
                rem = W;
            end
        end
        #1;
        check("D", int'(D), m_d);
        check("borrow", int'(borrow), m_b);
        check("busy", int'(busy), (rem > 0) ? 1 : 0);
        check("done", int'(done), m_done);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf), m_o);
`endif
    end

    task automatic op(input int x, input int y, input int ed, input int eb,
                      output int busy_cyc);
        bit got;
        @(negedge clk);
        start = 1'b1; X = W'(x); Y = W'(y);
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
        check("op_done_seen", int'(got), 1);
        check("op_D", int'(D), ed);
        check("op_borrow", int'(borrow), eb);
    endtask

    initial begin
        int bc;
        int ndone;
        rst_n = 1'b0; start = 1'b0; X = '0; Y = '0;
        repeat (2) @(negedge clk);
        check("rst_D", int'(D), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_borrow", int'(borrow), 0);
        rst_n = 1'b1;

        op(9, 3, 6, 0, bc);
        check("busy_cycles", bc, 4);
        op(3, 9, 10, 1, bc);
        op(0, 0, 0, 0, bc);
        op(15, 15, 0, 0, bc);

        // Second start during SHIFT must be ignored.
        @(negedge clk);
        start = 1'b1; X = 4'd5; Y = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; X = 4'd1; Y = 4'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                ndone++;
                check("ignore_D", int'(D), 3);
            end
            @(negedge clk);
        end
        check("ignore_ndone", ndone, 1);

        // Back-to-back with start held high.
        start = 1'b1; X = 4'd7; Y = 4'd1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("b2b_D", int'(D), 6);
            end
        end
        start = 1'b0;
        check("b2b_ndone", ndone, 3);
        repeat (6) @(negedge clk);

        // Reset in the middle of an operation.
        start = 1'b1; X = 4'd2; Y = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_D", int'(D), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_borrow", int'(borrow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(8, 8, 0, 0, bc);

`ifdef SERIAL_SUB_OVF_EN
        op(8, 1, 7, 0, bc);
        check("ovf_8_1", int'(ovf), 1);
        op(7, 15, 8, 1, bc);
        check("ovf_7_15", int'(ovf), 1);
        op(6, 2, 4, 0, bc);
        check("ovf_6_2", int'(ovf), 0);
`endif

        // Random traffic: operands wiggle every cycle, start is sparse.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            X = W'($urandom);
            Y = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
